// File: rtl/sdram_req_arbiter_pkg.sv
// Shared types and default parameters for the SDRAM requester arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      WAIT,
      DONE
   } arb_state_t;

   localparam int NUM_REQ_DEF  = 4;
   localparam int ADDR_W_DEF   = 24;
   localparam int SYNC_CYC_DEF = 16;

endpackage

// File: rtl/sdram_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] cand,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] idx
);

   always_comb begin
      any = |cand;
      idx = '0;
      // Walk from farthest to nearest so the nearest hit is the final write.
      for (int k = N - 1; k >= 0; k--) begin
         if (cand[W'((int'(ptr) + k) % N)]) idx = W'((int'(ptr) + k) % N);
      end
   end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM controller port.
// Optional single-entry read cache enabled by defining SDRAM_ARB_RDCACHE_EN.
module sdram_req_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int SYNC_CYC = SYNC_CYC_DEF
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               rq_req,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]   rq_addr,
   input  logic [NUM_REQ-1:0]               rq_wrl,
   input  logic [NUM_REQ-1:0]               rq_wrh,
   input  logic [NUM_REQ-1:0][15:0]         rq_din,
   output logic [NUM_REQ-1:0]               rq_ack,
   output logic [15:0]                      rq_dout,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic                             mem_wrl,
   output logic                             mem_wrh,
   output logic [15:0]                      mem_din,
   output logic                             mem_req,
   input  logic                             mem_ack,
   input  logic [15:0]                      mem_dout,
   output logic                             busy,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

   localparam int GID_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(SYNC_CYC + 1);

   arb_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_wrl_q, mem_wrl_d;
   logic                mem_wrh_q, mem_wrh_d;
   logic [15:0]         mem_din_q, mem_din_d;
   logic [15:0]         rq_dout_q, rq_dout_d;
   logic [GID_W-1:0]    grant_id_q, grant_id_d;
   logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                mask_en_q, mask_en_d;

   logic [NUM_REQ-1:0]  mask;
   logic [NUM_REQ-1:0]  cand;
   logic                pick_any;
   logic [GID_W-1:0]    pick_idx;

   // The just-served requester may still hold its request for the cycle after DONE.
   assign mask = mask_en_q ? (NUM_REQ'(1) << grant_id_q) : '0;
   assign cand = rq_req & ~mask;

   rr_pick #(
      .N (NUM_REQ),
      .W (GID_W)
   ) u_pick (
      .cand (cand),
      .ptr  (rr_ptr_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

`ifdef SDRAM_ARB_RDCACHE_EN
   logic                c_vld_q, c_vld_d;
   logic [ADDR_W-1:0]   c_addr_q, c_addr_d;
   logic [15:0]         c_data_q, c_data_d;
   logic                pick_wr;
   logic                c_hit;

   assign pick_wr = rq_wrl[pick_idx] | rq_wrh[pick_idx];
   assign c_hit   = c_vld_q && !pick_wr && (c_addr_q == rq_addr[pick_idx]);

   always_comb begin
      c_vld_d  = c_vld_q;
      c_addr_d = c_addr_q;
      c_data_d = c_data_q;
      if (state_q == IDLE && pick_any && pick_wr) begin
         c_vld_d = 1'b0;
      end else if (state_q == WAIT && mem_ack == mem_req_q && !mem_wrl_q && !mem_wrh_q) begin
         c_vld_d  = 1'b1;
         c_addr_d = mem_addr_q;
         c_data_d = mem_dout;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_vld_q  <= 1'b0;
         c_addr_q <= '0;
         c_data_q <= '0;
      end else begin
         c_vld_q  <= c_vld_d;
         c_addr_q <= c_addr_d;
         c_data_q <= c_data_d;
      end
   end
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      mem_wrl_d  = mem_wrl_q;
      mem_wrh_d  = mem_wrh_q;
      mem_din_d  = mem_din_q;
      rq_dout_d  = rq_dout_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      mask_en_d  = 1'b0;
      unique case (state_q)
         SYNC: begin
            // Track the controller so any in-flight slot drains without a fresh toggle.
            mem_req_d = mem_ack;
            if (cnt_q == CNT_W'(SYNC_CYC - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IDLE: begin
            if (pick_any) begin
               grant_id_d = pick_idx;
               rr_ptr_d   = (pick_idx == GID_W'(NUM_REQ - 1)) ? '0 : pick_idx + GID_W'(1);
`ifdef SDRAM_ARB_RDCACHE_EN
               if (c_hit) begin
                  rq_dout_d = c_data_q;
                  state_d   = DONE;
               end else
`endif
               begin
                  mem_addr_d = rq_addr[pick_idx];
                  mem_wrl_d  = rq_wrl[pick_idx];
                  mem_wrh_d  = rq_wrh[pick_idx];
                  mem_din_d  = rq_din[pick_idx];
                  mem_req_d  = ~mem_req_q;
                  state_d    = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_ack == mem_req_q) begin
               rq_dout_d = mem_dout;
               state_d   = DONE;
            end
         end
         DONE: begin
            mask_en_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SYNC;
         cnt_q      <= '0;
         mem_req_q  <= mem_ack;
         mem_addr_q <= '0;
         mem_wrl_q  <= 1'b0;
         mem_wrh_q  <= 1'b0;
         mem_din_q  <= '0;
         rq_dout_q  <= '0;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         mask_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         mem_wrl_q  <= mem_wrl_d;
         mem_wrh_q  <= mem_wrh_d;
         mem_din_q  <= mem_din_d;
         rq_dout_q  <= rq_dout_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         mask_en_q  <= mask_en_d;
      end
   end

   always_comb begin
      rq_ack = '0;
      if (state_q == DONE) rq_ack[grant_id_q] = 1'b1;
   end

   assign busy     = (state_q != IDLE);
   assign rq_dout  = rq_dout_q;
   assign mem_addr = mem_addr_q;
   assign mem_wrl  = mem_wrl_q;
   assign mem_wrh  = mem_wrh_q;
   assign mem_din  = mem_din_q;
   assign mem_req  = mem_req_q;
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter with a toggle-handshake SDRAM controller model.
module tb_sdram_req_arbiter;

   localparam int NR  = 4;
   localparam int AW  = 24;
   localparam int LAT = 6;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NR-1:0]          rq_req;
   logic [NR-1:0][AW-1:0]  rq_addr;
   logic [NR-1:0]          rq_wrl, rq_wrh;
   logic [NR-1:0][15:0]    rq_din;
   logic [NR-1:0]          rq_ack;
   logic [15:0]            rq_dout;
   logic [AW-1:0]          mem_addr;
   logic                   mem_wrl, mem_wrh;
   logic [15:0]            mem_din;
   logic                   mem_req;
   logic                   mem_ack = 1'b1;
   logic [15:0]            mem_dout = 16'h0;
   logic                   busy;
   logic [1:0]             grant_id;

   always #5 clk = ~clk;

   sdram_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .SYNC_CYC(16)) dut (
      .clk(clk), .reset(reset),
      .rq_req(rq_req), .rq_addr(rq_addr), .rq_wrl(rq_wrl), .rq_wrh(rq_wrh), .rq_din(rq_din),
      .rq_ack(rq_ack), .rq_dout(rq_dout),
      .mem_addr(mem_addr), .mem_wrl(mem_wrl), .mem_wrh(mem_wrh), .mem_din(mem_din),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_dout(mem_dout),
      .busy(busy), .grant_id(grant_id)
   );

   // Controller model: not reset by the arbiter, so in-flight slots finish on their own.
   logic [15:0] mem_m [logic [AW-1:0]];
   logic        m_pend = 1'b0;
   int          m_cnt  = 0;
   logic [15:0] m_rd, m_v;

   function automatic logic [15:0] rdm(input logic [AW-1:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return a[15:0] ^ 16'h5A5A;
   endfunction

   always @(posedge clk) begin
      if (m_pend) begin
         if (m_cnt == 1) begin
            m_pend   <= 1'b0;
            mem_ack  <= mem_req;
            mem_dout <= m_rd;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if ((mem_req ^ mem_ack) === 1'b1) begin
         m_pend <= 1'b1;
         m_cnt  <= LAT;
         m_v = rdm(mem_addr);
         if (mem_wrl) m_v[7:0]  = mem_din[7:0];
         if (mem_wrh) m_v[15:8] = mem_din[15:8];
         if (mem_wrl || mem_wrh) mem_m[mem_addr] = m_v;
         m_rd = m_v;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_txn(input int idx, input logic [AW-1:0] a, input logic wl, input logic wh,
                         input logic [15:0] d, input int hold, input int tail,
                         output int lat, output logic [15:0] dout, output int togs,
                         output int gid, output int extra, output logic got);
      logic prv;
      rq_addr[idx] = a;
      rq_wrl[idx]  = wl;
      rq_wrh[idx]  = wh;
      rq_din[idx]  = d;
      rq_req[idx]  = 1'b1;
      prv = mem_req; lat = 0; togs = 0; extra = 0; got = 1'b0; dout = '0; gid = -1;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         lat++;
         if (mem_req !== prv) begin togs++; prv = mem_req; end
         if (rq_ack[idx]) begin got = 1'b1; dout = rq_dout; gid = int'(grant_id); end
         if ((rq_ack & ~(NR'(1) << idx)) != '0) extra++;
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (mem_req !== prv) begin togs++; prv = mem_req; end
         if (rq_ack != '0) extra++;
      end
      rq_req[idx] = 1'b0;
      for (int k = 0; k < tail; k++) begin
         @(negedge clk);
         if (mem_req !== prv) begin togs++; prv = mem_req; end
         if (rq_ack != '0) extra++;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   int           lat, togs, gid, extra, cnt, cnt2;
   logic [15:0]  dout;
   logic         got, prv;
   int           ord_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   logic [15:0]  rr_dexp [4] = '{16'h5B5A, 16'h5B5B, 16'h5B58, 16'h5B59};
   int           rem [NR];
   int           nack;

   initial begin
      rq_req = '0; rq_addr = '0; rq_wrl = '0; rq_wrh = '0; rq_din = '0;
      reset = 1'b1;
      mem_m[24'h001234] = 16'hBEEF;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ack",   rq_ack,   0);
      chk("rst_dout",  rq_dout,  0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_mdin",  mem_din,  0);
      chk("rst_mwr",   {mem_wrh, mem_wrl}, 0);
      chk("rst_gid",   grant_id, 0);
      chk("rst_mreq",  mem_req,  1);
      chk("rst_busy",  busy,     1);

      // SYNC length and mem_req tracking mem_ack
      reset = 1'b0;
      cnt = 0; cnt2 = 0;
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         cnt++;
         if (mem_req !== 1'b1) cnt2++;
         @(negedge clk);
      end
      chk("sync_len", cnt, 16);
      chk("sync_req", cnt2, 0);
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         if (mem_req !== 1'b1 || busy !== 1'b0) cnt++;
         @(negedge clk);
      end
      chk("idle_quiet", cnt, 0);

      // Single read from requester 2
      do_txn(2, 24'h001234, 1'b0, 1'b0, 16'h0, 0, 3, lat, dout, togs, gid, extra, got);
      chk("rd_got",   got,  1);
      chk("rd_dout",  dout, 16'hBEEF);
      chk("rd_lat",   lat,  LAT + 3);
      chk("rd_togs",  togs, 1);
      chk("rd_gid",   gid,  2);
      chk("rd_extra", extra, 0);
      chk("rd_maddr", mem_addr, 24'h001234);

      // Full write, readback, low-byte write, readback
      do_txn(1, 24'h000200, 1'b1, 1'b1, 16'hCAFE, 0, 2, lat, dout, togs, gid, extra, got);
      chk("wr_got",  got, 1);
      chk("wr_togs", togs, 1);
      chk("wr_mdin", mem_din, 16'hCAFE);
      chk("wr_mwr",  {mem_wrh, mem_wrl}, 2'b11);
      do_txn(1, 24'h000200, 1'b0, 1'b0, 16'h0, 0, 2, lat, dout, togs, gid, extra, got);
      chk("wrrd_dout", dout, 16'hCAFE);
      do_txn(1, 24'h000201, 1'b1, 1'b0, 16'h77AA, 0, 2, lat, dout, togs, gid, extra, got);
      chk("bw_mwr", {mem_wrh, mem_wrl}, 2'b01);
      do_txn(1, 24'h000201, 1'b0, 1'b0, 16'h0, 0, 2, lat, dout, togs, gid, extra, got);
      chk("bwrd_dout", dout, 16'h58AA);

      // Requester keeps rq_req through the cycle after its ack: no second grant
      do_txn(3, 24'h000300, 1'b0, 1'b0, 16'h0, 2, 12, lat, dout, togs, gid, extra, got);
      chk("mask_dout",  dout, 16'h595A);
      chk("mask_togs",  togs, 1);
      chk("mask_extra", extra, 0);

      // Reset during WAIT abandons the transaction
      rq_addr[1] = 24'h000400; rq_wrl[1] = 1'b0; rq_wrh[1] = 1'b0; rq_req[1] = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_busy", busy, 1);
      reset = 1'b1; rq_req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rq_ack != '0) cnt++;
      end
      chk("mid_noack", cnt, 0);
      chk("mid_sync",  mem_req, mem_ack);
      chk("mid_idle",  busy, 0);
      do_txn(3, 24'h000500, 1'b0, 1'b0, 16'h0, 0, 2, lat, dout, togs, gid, extra, got);
      chk("mid_next_dout", dout, 16'h5F5A);
      chk("mid_next_lat",  lat,  LAT + 3);
      chk("mid_next_gid",  gid,  3);

      // All four requesters, two transactions each: strict round robin from pointer 0
      for (int i = 0; i < NR; i++) begin
         rq_addr[i] = AW'(24'h000100 + i);
         rq_wrl[i] = 1'b0; rq_wrh[i] = 1'b0;
         rem[i] = 2;
      end
      rq_req = '1;
      nack = 0;
      for (int k = 0; k < 200 && nack < 8; k++) begin
         @(negedge clk);
         if (rq_ack != '0) begin
            chk("rr_onehot", $countones(rq_ack), 1);
            for (int i = 0; i < NR; i++) begin
               if (rq_ack[i]) begin
                  chk($sformatf("rr_ord%0d", nack), i, ord_exp[nack]);
                  chk($sformatf("rr_dout%0d", nack), rq_dout, rr_dexp[i]);
                  nack++;
               end
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (rq_ack[i]) begin
               rem[i]--;
               rq_req[i] = 1'b0;
            end else if (!rq_req[i] && rem[i] > 0) begin
               rq_req[i] = 1'b1;
            end
         end
      end
      chk("rr_count", nack, 8);
      rq_req = '0;
      repeat (3) @(negedge clk);

`ifdef SDRAM_ARB_RDCACHE_EN
      // Repeat read hits the cache
      do_txn(0, 24'h000010, 1'b0, 1'b0, 16'h0, 0, 2, lat, dout, togs, gid, extra, got);
      chk("c_fill_togs", togs, 1);
      chk("c_fill_dout", dout, 16'h5A4A);
      do_txn(1, 24'h000010, 1'b0, 1'b0, 16'h0, 0, 2, lat, dout, togs, gid, extra, got);
      chk("c_hit_fast", (lat <= 2), 1);
      chk("c_hit_togs", togs, 0);
      chk("c_hit_dout", dout, 16'h5A4A);
      // Any write invalidates
      do_txn(2, 24'h000020, 1'b1, 1'b1, 16'h1357, 0, 2, lat, dout, togs, gid, extra, got);
      chk("c_inv_wtogs", togs, 1);
      do_txn(3, 24'h000010, 1'b0, 1'b0, 16'h0, 0, 2, lat, dout, togs, gid, extra, got);
      chk("c_inv_rtogs", togs, 1);
      chk("c_inv_dout",  dout, 16'h5A4A);
`endif

      prv = mem_req;
      chk("end_idle", busy, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
